// File: rtl/alu_pkg.sv
// Shared ALU function codes, ALUOp encodings and the issue-queue entry layout.
// Optional trap tracking is enabled by ALU_ISSUE_TRAP_EN.
package alu_pkg;
  localparam int ALU_W = 32;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_OR    = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [5:0]       signal;
    logic [ALU_W-1:0] data_a;
    logic [ALU_W-1:0] data_b;
`ifdef ALU_ISSUE_TRAP_EN
    logic             illegal;
`endif
  } entry_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// EX-side bus between the issue controller (master) and the ALU (slave).
// ALU_ISSUE_TRAP_EN adds the IllegalFunct/TrapSeen signals.
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);
  logic             OutValid;
  logic             OutReady;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
`ifdef ALU_ISSUE_TRAP_EN
  logic             IllegalFunct;
  logic             TrapSeen;
`endif

  modport master (
    output OutValid, Signal, DataA, DataB,
`ifdef ALU_ISSUE_TRAP_EN
    output IllegalFunct, TrapSeen,
`endif
    input  OutReady
  );

  modport slave (
    input  OutValid, Signal, DataA, DataB,
`ifdef ALU_ISSUE_TRAP_EN
    input  IllegalFunct, TrapSeen,
`endif
    output OutReady
  );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational ALUOp/Funct -> ALU function code translation.
// ALU_ISSUE_TRAP_EN adds the unsupported-funct flag.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
`ifdef ALU_ISSUE_TRAP_EN
  output logic       illegal,
`endif
  output logic [5:0] signal
);
  logic bad;

  always_comb begin
    signal = FN_ADD;
    bad    = 1'b0;
    case (alu_op)
      OP_ADD: signal = FN_ADD;
      OP_SUB: signal = FN_SUB;
      OP_OR:  signal = FN_OR;
      default: begin
        // Unsupported R-type funct falls back to ADD so the ALU never sees junk
        case (funct)
          FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL: signal = funct;
          default: bad = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_ISSUE_TRAP_EN
  assign illegal = bad;
`else
  logic unused_bad;
  assign unused_bad = bad;
`endif
endmodule

// File: rtl/alu_issue_ctrl.sv
// ID/EX issue stage: decodes the ALU function, selects operands and buffers
// them in a 2-entry skid queue. ALU_ISSUE_TRAP_EN enables illegal-funct tracking.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [4:0]       Shamt,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic [WIDTH-1:0] ImmExt,
  alu_issue_ctrl_if.master ex
);
  entry_t     ent [DEPTH];
  entry_t     nxt, head;
  logic [1:0] count;
  logic       wptr, rptr;
  logic       push, pop;
  logic [5:0] dec_signal;
`ifdef ALU_ISSUE_TRAP_EN
  logic       dec_illegal;
  logic       trap_q;
`endif

  alu_funct_decode u_dec (
    .alu_op (ALUOp),
    .funct  (Funct),
`ifdef ALU_ISSUE_TRAP_EN
    .illegal(dec_illegal),
`endif
    .signal (dec_signal)
  );

  always_comb begin
    nxt        = '0;
    nxt.signal = dec_signal;
    if (dec_signal == FN_SRL) begin
      nxt.data_a = RtData;
      nxt.data_b = {{(WIDTH-5){1'b0}}, Shamt};
    end else begin
      nxt.data_a = RsData;
      nxt.data_b = ALUSrc ? ImmExt : RtData;
    end
`ifdef ALU_ISSUE_TRAP_EN
    nxt.illegal = dec_illegal;
`endif
  end

  // Ready depends only on stored occupancy, so EX stall never reaches ID combinationally
  assign InReady     = !Reset && (count != 2'(DEPTH));
  assign ex.OutValid = (count != 2'd0);
  assign push        = InValid && InReady;
  assign pop         = ex.OutValid && ex.OutReady;
  assign head        = ent[rptr];

  assign ex.Signal = ex.OutValid ? head.signal : '0;
  assign ex.DataA  = ex.OutValid ? head.data_a : '0;
  assign ex.DataB  = ex.OutValid ? head.data_b : '0;
`ifdef ALU_ISSUE_TRAP_EN
  assign ex.IllegalFunct = ex.OutValid && head.illegal;
  assign ex.TrapSeen     = trap_q;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (Flush) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) begin
        ent[wptr] <= nxt;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_ISSUE_TRAP_EN
  // EX consumed the entry even if a flush lands the same cycle, so the trap still records it
  always_ff @(posedge clk) begin
    if (Reset)                    trap_q <= 1'b0;
    else if (pop && head.illegal) trap_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl (both ALU_ISSUE_TRAP_EN builds).
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        Reset, Flush, InValid, InReady, ALUSrc;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic [31:0] RsData, RtData, ImmExt;
  int checks = 0;
  int errors = 0;

  alu_issue_ctrl_if #(.WIDTH(32)) ex ();

  alu_issue_ctrl #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .ALUOp(ALUOp), .Funct(Funct), .Shamt(Shamt), .ALUSrc(ALUSrc),
    .RsData(RsData), .RtData(RtData), .ImmExt(ImmExt), .ex(ex.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    Reset = 1; Flush = 0; InValid = 0; ALUSrc = 0; ALUOp = 2'b00; Funct = '0;
    Shamt = '0; RsData = '0; RtData = '0; ImmExt = '0; ex.OutReady = 0;

    // Reset held two cycles
    sample(); check("rst_inready", 32'(InReady), 0);
    step(); step();
    Reset = 0;
    sample();
    check("rst_outvalid", 32'(ex.OutValid), 0);
    check("rst_signal", 32'(ex.Signal), 0);
    check("rst_dataa", ex.DataA, 0);
    check("rst_datab", ex.DataB, 0);
    check("rst_inready_after", 32'(InReady), 1);

    // SLT R-type, immediate drain
    ex.OutReady = 1; InValid = 1; ALUOp = 2'b10; Funct = 6'b101010;
    RsData = 5; RtData = 9; ALUSrc = 0;
    step(); InValid = 0;
    sample();
    check("slt_valid", 32'(ex.OutValid), 1);
    check("slt_signal", 32'(ex.Signal), 32'h2a);
    check("slt_a", ex.DataA, 5);
    check("slt_b", ex.DataB, 9);
    step(); sample();
    check("slt_drained", 32'(ex.OutValid), 0);
    check("slt_zero_sig", 32'(ex.Signal), 0);

    // SRL swaps in Rt as A and shamt as B
    InValid = 1; Funct = 6'b000010; Shamt = 3; RtData = 32'h80; RsData = 32'h55;
    step(); InValid = 0;
    sample();
    check("srl_signal", 32'(ex.Signal), 32'h02);
    check("srl_a", ex.DataA, 32'h80);
    check("srl_b", ex.DataB, 3);
    step();

    // ori with immediate operand
    InValid = 1; ALUOp = 2'b11; ALUSrc = 1; RsData = 32'h1234; ImmExt = 32'hf0;
    step(); InValid = 0;
    sample();
    check("ori_signal", 32'(ex.Signal), 32'h25);
    check("ori_a", ex.DataA, 32'h1234);
    check("ori_b", ex.DataB, 32'hf0);
    step();

    // Back-pressure: three lw with EX stalled
    ex.OutReady = 0; InValid = 1; ALUOp = 2'b00; ALUSrc = 1; ImmExt = 4;
    step(); ImmExt = 8;
    sample();
    check("bp_ready1", 32'(InReady), 1);
    check("bp_head1", ex.DataB, 4);
    check("bp_sig1", 32'(ex.Signal), 32'h20);
    step(); ImmExt = 12;
    sample();
    check("bp_full", 32'(InReady), 0);
    check("bp_head2", ex.DataB, 4);
    step();
    sample();
    check("bp_hold_ready", 32'(InReady), 0);
    check("bp_hold_b", ex.DataB, 4);
    ex.OutReady = 1;
    step();
    sample();
    check("bp_pop1_b", ex.DataB, 8);
    check("bp_pop1_ready", 32'(InReady), 1);
    step(); InValid = 0;
    sample();
    check("bp_pushpop_valid", 32'(ex.OutValid), 1);
    check("bp_pushpop_b", ex.DataB, 12);
    step(); sample();
    check("bp_empty", 32'(ex.OutValid), 0);

    // Flush on a full queue with an incoming instruction
    ex.OutReady = 0; InValid = 1; ImmExt = 32'h11;
    step(); ImmExt = 32'h22;
    step(); ImmExt = 32'h33; Flush = 1;
    sample();
    check("fl_full", 32'(InReady), 0);
    step(); Flush = 0; InValid = 0;
    sample();
    check("fl_valid", 32'(ex.OutValid), 0);
    check("fl_ready", 32'(InReady), 1);
    check("fl_b", ex.DataB, 0);
    step(); sample();
    check("fl_still_empty", 32'(ex.OutValid), 0);
    ex.OutReady = 1; InValid = 1; ImmExt = 32'h44;
    step(); InValid = 0;
    sample();
    check("fl_next_b", ex.DataB, 32'h44);
    step(); sample();
    check("fl_next_empty", 32'(ex.OutValid), 0);

    // Unsupported funct maps to ADD
    ex.OutReady = 0; InValid = 1; ALUOp = 2'b10; Funct = 6'b111111;
    ALUSrc = 0; RsData = 7; RtData = 6;
    step(); InValid = 0;
    sample();
    check("bad_signal", 32'(ex.Signal), 32'h20);
    check("bad_a", ex.DataA, 7);
`ifdef ALU_ISSUE_TRAP_EN
    check("bad_illegal", 32'(ex.IllegalFunct), 1);
    check("bad_trap_pre", 32'(ex.TrapSeen), 0);
`endif
    ex.OutReady = 1;
    step(); sample();
    check("bad_popped", 32'(ex.OutValid), 0);
`ifdef ALU_ISSUE_TRAP_EN
    check("trap_set", 32'(ex.TrapSeen), 1);
    check("illegal_clear", 32'(ex.IllegalFunct), 0);
    InValid = 1; Funct = 6'b100100;
    step(); InValid = 0;
    sample();
    check("and_signal", 32'(ex.Signal), 32'h24);
    check("and_legal", 32'(ex.IllegalFunct), 0);
    step(); sample();
    check("trap_sticky", 32'(ex.TrapSeen), 1);
`endif

    // Reset mid-stream drops queued entries
    ex.OutReady = 0; InValid = 1; ALUOp = 2'b01; RsData = 3;
    step(); InValid = 0;
    sample();
    check("mid_sub", 32'(ex.Signal), 32'h22);
    Reset = 1;
    step(); Reset = 0;
    sample();
    check("mid_rst_valid", 32'(ex.OutValid), 0);
    check("mid_rst_sig", 32'(ex.Signal), 0);
`ifdef ALU_ISSUE_TRAP_EN
    check("trap_cleared", 32'(ex.TrapSeen), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Producer side of the 32-bit ALU interface: generates the registered 6-bit function `Signal` and the `DataA`/`DataB` operands that the ALU consumes.
- Sits at the ID/EX boundary. Takes decoded instruction fields from ID and translates ALUOp/funct into an ALU function code.
- Selects the operands, then buffers the result in a 2-entry skid queue with valid/ready handshakes on both sides, so EX back-pressure never combinationally reaches ID.

Parameters:
- WIDTH, 32, operand/data width
- DEPTH, 2, skid queue entries (fixed at 2; the only legal value)

Ports:
- clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Flush  input  1  discards all queued entries (branch/jump squash)
- InValid  input  1  ID presents a valid instruction
- InReady  output  1  queue can accept this cycle
- ALUOp  input  2  00 add(lw/sw), 01 sub(beq), 10 R-type (use Funct), 11 or(ori)
- Funct  input  6  R-type funct field
- Shamt  input  5  shift amount field
- ALUSrc  input  1  1 selects ImmExt as DataB
- RsData  input  WIDTH  rs register value
- RtData  input  WIDTH  rt register value
- ImmExt  input  WIDTH  extended immediate
- OutValid  output  1  head entry valid toward EX
- OutReady  input  1  EX consumes head this cycle
- Signal  output  6  ALU function code of head entry
- DataA  output  WIDTH  ALU operand A of head entry
- DataB  output  WIDTH  ALU operand B of head entry

Behaviour:
- Reset: count=0, both entries cleared. OutValid=0, Signal=0, DataA=0, DataB=0. InReady=0 during the Reset cycle and 1 from the next cycle.
- Decode, per accepted instruction:
  - ALUOp 00 -> 100000 (ADD); 01 -> 100010 (SUB); 11 -> 100101 (OR).
  - ALUOp 10 -> Funct if Funct is one of {100100, 100101, 100000, 100010, 101010, 000010}; any other Funct -> 100000 (ADD, treated as a nop-safe default).
- Operands:
  - SRL (Signal 000010): DataA = RtData, DataB = {27'b0, Shamt}.
  - Otherwise: DataA = RsData, DataB = ALUSrc ? ImmExt : RtData.
- Handshakes:
  - Push when InValid & InReady.
  - Pop when OutValid & OutReady.
  - InReady = (count != 2). It is derived from registered count only.
  - OutValid = (count != 0).
- Latency: an instruction accepted in cycle N appears on Signal/DataA/DataB with OutValid=1 in cycle N+1 (if the queue was empty).
- FIFO order is strict; the head is always the oldest entry.
- Count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop at count 1: count stays 1; the new entry becomes head in the next cycle.
  - push and pop at count 0: impossible, since OutValid=0.
  - count 2: no push possible.
- Outputs are held stable while OutValid=1 and OutReady=0.
- While empty, Signal/DataA/DataB are driven to 0.
- Flush: next cycle count=0 and outputs go to 0. Flush wins over a simultaneous push and pop; the incoming instruction is dropped.
- Reset has priority over Flush and everything else. Reset mid-stream drops all entries.
- Pointers: 1-bit read/write pointers wrap modulo 2.

Optional Feature:
- Macro ALU_ISSUE_TRAP_EN.
- Defined:
  - Adds output IllegalFunct (1 bit, reset 0). It is queued alongside each entry and equals 1 when ALUOp=10 and Funct is unsupported.
  - The entry still carries Signal=100000.
  - Adds a sticky output TrapSeen, set when an illegal entry is popped and cleared only by Reset.
- Not defined: neither port exists; unsupported Funct silently maps to ADD.

Decomposition:
- Package alu_pkg holds:
  - function-code constants AND/OR/ADD/SUB/SLT/SRL with the 6-bit values above;
  - ALUOp encodings;
  - a packed entry struct {signal, dataA, dataB [, illegal]}.
- Sub-module alu_funct_decode: purely combinational ALUOp/Funct -> Signal (+ illegal flag), reused by the ALU-side checker.
- The queue and handshake logic stay in alu_issue_ctrl.

Test Plan:
- Reset held 2 cycles, then released -> OutValid=0, Signal=0, InReady=1 the cycle after release.
- Push ALUOp=10, Funct=101010, Rs=5, Rt=9, ALUSrc=0, with OutReady=1 -> next cycle OutValid=1, Signal=101010, DataA=5, DataB=9; OutValid=0 the cycle after.
- Push ALUOp=10, Funct=000010, Shamt=3, Rt=0x80 -> Signal=000010, DataA=0x80, DataB=3.
- OutReady=0, push 3 back-to-back lw (ALUOp=00, Imm=4, 8, 12) -> InReady drops to 0 after two pushes. The third is held by ID. Raising OutReady yields DataB 4, 8, 12 in order.
- Queue full, assert Flush together with InValid=1 -> next cycle OutValid=0, count=0; the flushed and incoming entries never appear.
- ALUOp=10, Funct=111111 -> Signal=100000. With ALU_ISSUE_TRAP_EN: IllegalFunct=1, and TrapSeen=1 after the pop until Reset.
